// File: rtl/rr_request_arbiter.sv
// Round-robin request arbiter with registered one-hot grant held until release.
// Optional burst limit enabled by defining RR_ARB_BURST_LIMIT_EN.
module rr_request_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                     clk_i,
    input  logic                     srst_i,
    input  logic [WIDTH-1:0]         req_i,
    output logic [WIDTH-1:0]         gnt_o,
    output logic                     gnt_valid_o,
    output logic [$clog2(WIDTH)-1:0] gnt_idx_o
);

    localparam int IW = $clog2(WIDTH);

    // Reject configurations the arbiter cannot implement
    if (WIDTH < 2 || MAX_BURST < 1) begin : g_bad_cfg
        $error("rr_request_arbiter: WIDTH must be >= 2 and MAX_BURST >= 1");
    end

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [IW-1:0]    ptr;
    logic [IW-1:0]    ptr_n;
    logic [WIDTH-1:0] gnt_n;
    logic             vld_n;
    logic [IW-1:0]    idx_n;

    logic [WIDTH-1:0] hold_oh;
    logic [WIDTH-1:0] others;
    logic [IW-1:0]    after;
    logic             switch_now;

    // Lowest set bit at or above start, else lowest set bit overall
    function automatic logic [IW-1:0] pick(
        input logic [WIDTH-1:0] v,
        input logic [IW-1:0]    start
    );
        logic [IW-1:0] lo;
        logic [IW-1:0] hi;
        logic          hit;
        lo  = '0;
        hi  = '0;
        hit = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (v[i]) begin
                lo = IW'(i);
                if (i >= int'(start)) begin
                    hi  = IW'(i);
                    hit = 1'b1;
                end
            end
        end
        return hit ? hi : lo;
    endfunction

    assign hold_oh = WIDTH'(1) << gnt_idx_o;
    assign others  = req_i & ~hold_oh;
    assign after   = (gnt_idx_o == IW'(WIDTH - 1)) ? '0 : IW'(gnt_idx_o + 1'b1);

`ifdef RR_ARB_BURST_LIMIT_EN
    localparam int CW = $clog2(MAX_BURST) + 1;

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic          at_limit;

    assign at_limit   = (cnt == CW'(MAX_BURST - 1));
    assign switch_now = !req_i[gnt_idx_o] || (at_limit && (|others));
`else
    assign switch_now = !req_i[gnt_idx_o];
`endif

    // Next-state, pointer and grant selection
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        gnt_n   = gnt_o;
        vld_n   = gnt_valid_o;
        idx_n   = gnt_idx_o;
`ifdef RR_ARB_BURST_LIMIT_EN
        cnt_n   = cnt;
`endif
        unique case (state)
            IDLE: begin
                if (|req_i) begin
                    idx_n   = pick(req_i, ptr);
                    gnt_n   = WIDTH'(1) << idx_n;
                    vld_n   = 1'b1;
                    state_n = BUSY;
`ifdef RR_ARB_BURST_LIMIT_EN
                    cnt_n   = '0;
`endif
                end
            end
            BUSY: begin
                if (switch_now) begin
                    ptr_n = after;
                    if (|others) begin
                        idx_n = pick(others, after);
                        gnt_n = WIDTH'(1) << idx_n;
`ifdef RR_ARB_BURST_LIMIT_EN
                        cnt_n = '0;
`endif
                    end else begin
                        gnt_n   = '0;
                        vld_n   = 1'b0;
                        state_n = IDLE;
                    end
                end else begin
`ifdef RR_ARB_BURST_LIMIT_EN
                    cnt_n = at_limit ? '0 : cnt + 1'b1;
`endif
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, pointer and registered grant outputs
    always_ff @(posedge clk_i) begin
        if (!srst_i) begin
            state       <= IDLE;
            ptr         <= '0;
            gnt_o       <= '0;
            gnt_valid_o <= 1'b0;
            gnt_idx_o   <= '0;
        end else begin
            state       <= state_n;
            ptr         <= ptr_n;
            gnt_o       <= gnt_n;
            gnt_valid_o <= vld_n;
            gnt_idx_o   <= idx_n;
        end
    end

`ifdef RR_ARB_BURST_LIMIT_EN
    // Consecutive-grant counter for the current holder
    always_ff @(posedge clk_i) begin
        if (!srst_i) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_n;
        end
    end
`endif

endmodule

// File: tb/tb_rr_request_arbiter.sv
// Directed self-checking bench for rr_request_arbiter (WIDTH=8, MAX_BURST=4).
// Burst-limit vectors run only when RR_ARB_BURST_LIMIT_EN is defined.
module tb_rr_request_arbiter;

    logic       clk;
    logic       srst;
    logic [7:0] req;
    logic [7:0] gnt;
    logic       gnt_valid;
    logic [2:0] gnt_idx;

    int n_cmp;
    int n_bad;

    rr_request_arbiter #(
        .WIDTH     (8),
        .MAX_BURST (4)
    ) dut (
        .clk_i       (clk),
        .srst_i      (srst),
        .req_i       (req),
        .gnt_o       (gnt),
        .gnt_valid_o (gnt_valid),
        .gnt_idx_o   (gnt_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [7:0] eg, input logic ev, input logic [2:0] ei);
        check({tag, ".gnt"}, 32'(gnt), 32'(eg));
        check({tag, ".vld"}, 32'(gnt_valid), 32'(ev));
        check({tag, ".idx"}, 32'(gnt_idx), 32'(ei));
    endtask

    initial begin
        logic [2:0] e;
        n_cmp = 0;
        n_bad = 0;
        srst  = 1'b0;
        req   = 8'h00;
        step();
        step();
        check_out("reset", 8'h00, 1'b0, 3'd0);
        srst = 1'b1;

        // Idle with no requests
        for (int i = 0; i < 5; i++) begin
            step();
            check_out("idle", 8'h00, 1'b0, 3'd0);
        end

        // First grant goes to bit 2, held regardless of bit 5
        req = 8'b0010_0100;
        step();
        check_out("first", 8'h04, 1'b1, 3'd2);
        for (int i = 0; i < 10; i++) begin
            req = (i % 2 == 0) ? 8'h04 : 8'h24;
            step();
            check_out("hold", 8'h04, 1'b1, 3'd2);
        end

        // Release 2 with 5 pending, then wrap back to 2
        req = 8'h20;
        step();
        check_out("sw5", 8'h20, 1'b1, 3'd5);
        req = 8'h04;
        step();
        check_out("wrap", 8'h04, 1'b1, 3'd2);
        req = 8'h00;
        step();
        check_out("drop", 8'h00, 1'b0, 3'd2);

        // Full rotation with each holder releasing after 3 cycles
        srst = 1'b0;
        step();
        srst = 1'b1;
        req  = 8'hFF;
        step();
        for (int g = 0; g < 9; g++) begin
            e = 3'(g % 8);
            for (int c = 0; c < 3; c++) begin
                if (c == 0) req = 8'hFF;
                check_out("rot", 8'(1) << e, 1'b1, e);
                if (c == 2) req = 8'hFF & ~(8'(1) << e);
                step();
            end
        end
        check_out("rot_end", 8'h02, 1'b1, 3'd1);

        // Reset mid-grant clears pointer
        req = 8'h20;
        step();
        check_out("pre_rst", 8'h20, 1'b1, 3'd5);
        srst = 1'b0;
        step();
        check_out("mid_rst", 8'h00, 1'b0, 3'd0);
        srst = 1'b1;
        req  = 8'b1000_0001;
        step();
        check_out("post_rst", 8'h01, 1'b1, 3'd0);

        // Two constant requesters
        srst = 1'b0;
        req  = 8'h03;
        step();
        srst = 1'b1;
        step();
        for (int i = 0; i < 16; i++) begin
`ifdef RR_ARB_BURST_LIMIT_EN
            e = 3'((i / 4) % 2);
`else
            e = 3'd0;
`endif
            check_out("burst", 8'(1) << e, 1'b1, e);
            step();
        end
`ifdef RR_ARB_BURST_LIMIT_EN
        req = 8'h01;
        step();
        for (int i = 0; i < 10; i++) begin
            check_out("solo", 8'h01, 1'b1, 3'd0);
            step();
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
